// File: rtl/peripheral_gpio_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : peripheral_gpio_debounce
//  Purpose  : Pad-side input conditioner for peripheral_gpio_apb4.
//             Synchronises raw pad inputs, debounces each bit with a
//             programmable stability counter, and records sticky per-bit
//             rising/falling edge status with a level interrupt.
//  Ports    : PCLK, PRESET     - clock, synchronous active-high reset
//             pad_i            - raw asynchronous pad inputs
//             debounce_limit   - stability threshold L (shared, quasi-static)
//             rise_en, fall_en - per-bit edge status enables
//             status_clr       - write-1-to-clear strobe for status
//             gpio_i           - debounced value (registered)
//             status_o         - sticky edge status
//             irq_o            - OR of all status bits
//  Option   : PERIPHERAL_GPIO_DEBOUNCE_LEVEL_IRQ_EN adds level_en/level_pol
//             inputs; status then also sets while db[i]==level_pol[i].
//  Revision : 1.0 - initial release
// ============================================================================
module peripheral_gpio_debounce #(
    parameter int PDATA_SIZE = 8,
    parameter int SYNC_DEPTH = 3,
    parameter int CNT_SIZE   = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [PDATA_SIZE-1:0] pad_i,
    input  logic [CNT_SIZE-1:0]   debounce_limit,
    input  logic [PDATA_SIZE-1:0] rise_en,
    input  logic [PDATA_SIZE-1:0] fall_en,
    input  logic [PDATA_SIZE-1:0] status_clr,
`ifdef PERIPHERAL_GPIO_DEBOUNCE_LEVEL_IRQ_EN
    input  logic [PDATA_SIZE-1:0] level_en,
    input  logic [PDATA_SIZE-1:0] level_pol,
`endif
    output logic [PDATA_SIZE-1:0] gpio_i,
    output logic [PDATA_SIZE-1:0] status_o,
    output logic                  irq_o
);

    localparam logic [CNT_SIZE-1:0] c_cnt_zero = '0;
    localparam logic [CNT_SIZE-1:0] c_cnt_one  = {{(CNT_SIZE-1){1'b0}}, 1'b1};

    logic [PDATA_SIZE-1:0] r_sync [SYNC_DEPTH];
    logic [PDATA_SIZE-1:0] r_db;
    logic [PDATA_SIZE-1:0] r_db_q;     // db one cycle earlier, for edge detect
    logic [PDATA_SIZE-1:0] r_status;
    logic [PDATA_SIZE-1:0] w_sync;
    logic [PDATA_SIZE-1:0] w_upd;      // bit takes its synchronised value this cycle
    logic [PDATA_SIZE-1:0] w_rise;
    logic [PDATA_SIZE-1:0] w_fall;
    logic [PDATA_SIZE-1:0] w_set;

    // Synchroniser chain: stage 0 captures the pad, last stage feeds debounce.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int s = 0; s < SYNC_DEPTH; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= pad_i;
            for (int s = 1; s < SYNC_DEPTH; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_DEPTH-1];

    // Per-bit stability counter. The counter saturates at L because it only
    // increments while below L, so lowering L mid-count simply lets the >=
    // compare fire on the next cycle.
    for (genvar i = 0; i < PDATA_SIZE; i++) begin : g_bit
        logic [CNT_SIZE-1:0] r_cnt;
        logic                w_mismatch;

        assign w_mismatch = w_sync[i] ^ r_db[i];
        assign w_upd[i]   = w_mismatch && (r_cnt >= debounce_limit);

        always_ff @(posedge PCLK) begin
            if (PRESET) begin
                r_cnt <= c_cnt_zero;
            end else if (!w_mismatch || w_upd[i]) begin
                r_cnt <= c_cnt_zero;
            end else begin
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

    // Edge events are seen the cycle after db changes, so status lands one
    // cycle after gpio_i.
    assign w_rise = r_db & ~r_db_q;
    assign w_fall = ~r_db & r_db_q;

`ifdef PERIPHERAL_GPIO_DEBOUNCE_LEVEL_IRQ_EN
    assign w_set = (w_rise & rise_en) | (w_fall & fall_en) |
                   (level_en & ~(r_db ^ level_pol));
`else
    assign w_set = (w_rise & rise_en) | (w_fall & fall_en);
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_db     <= '0;
            r_db_q   <= '0;
            r_status <= '0;
        end else begin
            r_db     <= (r_db & ~w_upd) | (w_sync & w_upd);
            r_db_q   <= r_db;
            // Set has priority over a coincident clear.
            r_status <= (r_status & ~status_clr) | w_set;
        end
    end

    assign gpio_i   = r_db;
    assign status_o = r_status;
    assign irq_o    = |r_status;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_gpio_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_peripheral_gpio_debounce
//  Purpose  : Directed self-checking bench for peripheral_gpio_debounce
//             (PDATA_SIZE=8, SYNC_DEPTH=3, CNT_SIZE=16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_gpio_debounce;

    logic        clk;
    logic        rst;
    logic [7:0]  r_pad;
    logic [15:0] r_limit;
    logic [7:0]  r_rise_en;
    logic [7:0]  r_fall_en;
    logic [7:0]  r_clr;
`ifdef PERIPHERAL_GPIO_DEBOUNCE_LEVEL_IRQ_EN
    logic [7:0]  r_level_en;
    logic [7:0]  r_level_pol;
`endif
    logic [7:0]  w_gpio;
    logic [7:0]  w_status;
    logic        w_irq;

    int checks   = 0;
    int failures = 0;

    peripheral_gpio_debounce #(
        .PDATA_SIZE (8),
        .SYNC_DEPTH (3),
        .CNT_SIZE   (16)
    ) u_dut (
        .PCLK           (clk),
        .PRESET         (rst),
        .pad_i          (r_pad),
        .debounce_limit (r_limit),
        .rise_en        (r_rise_en),
        .fall_en        (r_fall_en),
        .status_clr     (r_clr),
`ifdef PERIPHERAL_GPIO_DEBOUNCE_LEVEL_IRQ_EN
        .level_en       (r_level_en),
        .level_pol      (r_level_pol),
`endif
        .gpio_i         (w_gpio),
        .status_o       (w_status),
        .irq_o          (w_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; inputs change and outputs are sampled 1ns later.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        r_pad     = 8'h00;
        r_limit   = 16'd4;
        r_rise_en = 8'h00;
        r_fall_en = 8'h00;
        r_clr     = 8'h00;
`ifdef PERIPHERAL_GPIO_DEBOUNCE_LEVEL_IRQ_EN
        r_level_en  = 8'h00;
        r_level_pol = 8'h00;
`endif
        // Reset state
        tick(2);
        rst = 1'b0;
        check("rst_gpio", {24'h0, w_gpio}, 32'h00);
        check("rst_status", {24'h0, w_status}, 32'h00);
        check("rst_irq", {31'h0, w_irq}, 32'h0);

        // Latency: 3 sync + 4 + 1 = 8 edges
        tick(3);
        r_pad = 8'h01;
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check("lat_hold", {24'h0, w_gpio}, 32'h00);
        end
        tick(1);
        check("lat_8th", {24'h0, w_gpio}, 32'h01);
        check("lat_status", {24'h0, w_status}, 32'h00);

        // Glitch: 4-cycle pulse rejected
        tick(3);
        r_pad = 8'h05;
        tick(4);
        r_pad = 8'h01;
        tick(20);
        check("glitch4_gpio", {24'h0, w_gpio}, 32'h01);
        check("glitch4_status", {24'h0, w_status}, 32'h00);
        // 5-cycle pulse accepted, visible 8 edges after it starts
        r_pad = 8'h05;
        tick(5);
        r_pad = 8'h01;
        tick(2);
        check("pulse5_pre", {24'h0, w_gpio}, 32'h01);
        tick(1);
        check("pulse5_gpio", {24'h0, w_gpio}, 32'h05);
        tick(10);
        check("pulse5_back", {24'h0, w_gpio}, 32'h01);

        // Edge status with L=0
        r_limit = 16'd0;
        r_pad   = 8'h80;
        tick(10);
        check("setup_gpio", {24'h0, w_gpio}, 32'h80);
        check("setup_status", {24'h0, w_status}, 32'h00);
        r_rise_en = 8'h01;
        r_fall_en = 8'h80;
        r_pad     = 8'h01;
        tick(3);
        check("edge_pre", {24'h0, w_gpio}, 32'h80);
        tick(1);
        check("edge_gpio", {24'h0, w_gpio}, 32'h01);
        check("edge_status_lag", {24'h0, w_status}, 32'h00);
        check("edge_irq_lag", {31'h0, w_irq}, 32'h0);
        tick(1);
        check("edge_status", {24'h0, w_status}, 32'h81);
        check("edge_irq", {31'h0, w_irq}, 32'h1);

        // Clear bit0
        r_clr = 8'h01;
        tick(1);
        r_clr = 8'h00;
        check("clr0_status", {24'h0, w_status}, 32'h80);
        check("clr0_irq", {31'h0, w_irq}, 32'h1);
        // Clear coincident with a new bit7 fall: set wins
        r_pad = 8'h81;
        tick(5);
        check("b7_high", {24'h0, w_gpio}, 32'h81);
        r_pad = 8'h01;
        tick(4);
        check("b7_low", {24'h0, w_gpio}, 32'h01);
        r_clr = 8'h80;
        tick(1);
        r_clr = 8'h00;
        check("clr_vs_set", {24'h0, w_status}, 32'h80);
        r_clr = 8'h80;
        tick(1);
        r_clr = 8'h00;
        check("clr7_status", {24'h0, w_status}, 32'h00);
        check("clr7_irq", {31'h0, w_irq}, 32'h0);
        // Clearing an enable does not retro-clear; nothing pending anyway
        tick(2);
        check("idle_status", {24'h0, w_status}, 32'h00);

        // Reset mid-count with L=100
        r_limit = 16'd100;
        r_pad   = 8'h09;
        tick(53);
        check("mid_gpio", {24'h0, w_gpio}, 32'h01);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_gpio", {24'h0, w_gpio}, 32'h00);
        check("mid_rst_status", {24'h0, w_status}, 32'h00);
        tick(103);
        check("mid_hold", {24'h0, w_gpio}, 32'h00);
        tick(1);
        check("mid_update", {24'h0, w_gpio}, 32'h09);
        tick(1);
        check("mid_rise_status", {24'h0, w_status}, 32'h01);
        check("mid_rise_irq", {31'h0, w_irq}, 32'h1);

`ifdef PERIPHERAL_GPIO_DEBOUNCE_LEVEL_IRQ_EN
        // Level-sensitive status on bit2
        r_limit = 16'd0;
        r_clr   = 8'hFF;
        tick(1);
        r_clr   = 8'h00;
        check("lvl_clean", {24'h0, w_status}, 32'h00);
        r_level_en  = 8'h04;
        r_level_pol = 8'h04;
        r_pad       = 8'h0D;
        tick(4);
        check("lvl_gpio", {24'h0, w_gpio}, 32'h0D);
        tick(1);
        check("lvl_set", {24'h0, w_status}, 32'h04);
        r_clr = 8'h04;
        tick(1);
        r_clr = 8'h00;
        check("lvl_reset_by_level", {24'h0, w_status}, 32'h04);
        r_pad = 8'h09;
        tick(5);
        check("lvl_gpio_low", {24'h0, w_gpio}, 32'h09);
        r_clr = 8'h04;
        tick(1);
        r_clr = 8'h00;
        check("lvl_cleared", {24'h0, w_status}, 32'h00);
        check("lvl_irq", {31'h0, w_irq}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
